// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips a rectangle to the frame and streams one pixel write per cycle
// in raster order, and swaps display/draw pages on a synchronized vsync when idle.
module rect_fill_engine #(
    parameter int H_RES = 320,
    parameter int V_RES = 240
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       START,
    input  logic [8:0] RECT_X0,
    input  logic [8:0] RECT_Y0,
    input  logic [8:0] RECT_W,
    input  logic [8:0] RECT_H,
    input  logic [7:0] COLOR,
    input  logic       FLIP_REQ,
    input  logic       VGA_VS,
    output logic       WE,
    output logic [8:0] PIXEL_X,
    output logic [8:0] PIXEL_Y,
    output logic [7:0] PIXEL_DIN,
    output logic       PAGE_SEL,
    output logic       BUSY,
    output logic       DONE
);

    // state | meaning
    // IDLE  | waiting for START or a pending page flip
    // CLIP  | clip the latched rectangle against the frame
    // FILL  | one pixel write per cycle in raster order
    // FIN   | one-cycle DONE pulse
    typedef enum logic [1:0] {IDLE, CLIP, FILL, FIN} state_t;

    localparam logic [9:0] H_LIM = 10'(H_RES);
    localparam logic [9:0] V_LIM = 10'(V_RES);

    state_t     state;
    logic [8:0] x0_q, y0_q, w_q, h_q;
    logic [9:0] x_end, y_end;
    logic [9:0] x_sum, y_sum;
    logic       vs_s1, vs_s2, vs_s3;
    logic       flip_pending;
    logic       vs_event, flip_now, empty, x_last, y_last;

    assign x_sum    = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum    = {1'b0, y0_q} + {1'b0, h_q};
    assign empty    = (w_q == 9'd0) || (h_q == 9'd0) ||
                      ({1'b0, x0_q} >= H_LIM) || ({1'b0, y0_q} >= V_LIM);
    assign x_last   = ({1'b0, PIXEL_X} + 10'd1) == x_end;
    assign y_last   = ({1'b0, PIXEL_Y} + 10'd1) == y_end;
    assign vs_event = vs_s3 & ~vs_s2;
    assign flip_now = vs_event && flip_pending && (state == IDLE);
    assign BUSY     = (state != IDLE) || flip_pending;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state        <= IDLE;
            WE           <= 1'b0;
            DONE         <= 1'b0;
            PAGE_SEL     <= 1'b0;
            flip_pending <= 1'b0;
            PIXEL_X      <= '0;
            PIXEL_Y      <= '0;
            PIXEL_DIN    <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            x_end        <= '0;
            y_end        <= '0;
            vs_s1        <= 1'b1;
            vs_s2        <= 1'b1;
            vs_s3        <= 1'b1;
        end else begin
            vs_s1 <= VGA_VS;
            vs_s2 <= vs_s1;
            vs_s3 <= vs_s2;

            // A flip taken this cycle wins over a coincident repeat request.
            if (flip_now)
                flip_pending <= 1'b0;
            else if (FLIP_REQ)
                flip_pending <= 1'b1;

            case (state)
                IDLE: begin
                    WE   <= 1'b0;
                    DONE <= 1'b0;
                    if (flip_now) begin
                        PAGE_SEL <= ~PAGE_SEL;
                    end else if (START && !flip_pending) begin
                        x0_q      <= RECT_X0;
                        y0_q      <= RECT_Y0;
                        w_q       <= RECT_W;
                        h_q       <= RECT_H;
                        PIXEL_DIN <= COLOR;
                        state     <= CLIP;
                    end
                end
                CLIP: begin
                    x_end <= (x_sum > H_LIM) ? H_LIM : x_sum;
                    y_end <= (y_sum > V_LIM) ? V_LIM : y_sum;
                    if (empty) begin
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else begin
                        WE      <= 1'b1;
                        PIXEL_X <= x0_q;
                        PIXEL_Y <= y0_q;
                        state   <= FILL;
                    end
                end
                FILL: begin
                    if (x_last) begin
                        if (y_last) begin
                            WE    <= 1'b0;
                            DONE  <= 1'b1;
                            state <= FIN;
                        end else begin
                            PIXEL_X <= x0_q;
                            PIXEL_Y <= PIXEL_Y + 9'd1;
                        end
                    end else begin
                        PIXEL_X <= PIXEL_X + 9'd1;
                    end
                end
                FIN: begin
                    WE    <= 1'b0;
                    DONE  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed self-checking bench for rect_fill_engine: fills, clipping, empty rectangles,
// deferred page flips, ignored START pulses and mid-fill reset.
module tb_rect_fill_engine;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [8:0] RECT_X0 = '0, RECT_Y0 = '0, RECT_W = '0, RECT_H = '0;
    logic [7:0] COLOR = '0;
    logic       FLIP_REQ = 1'b0;
    logic       VGA_VS = 1'b1;
    logic       WE, PAGE_SEL, BUSY, DONE;
    logic [8:0] PIXEL_X, PIXEL_Y;
    logic [7:0] PIXEL_DIN;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int done_count = 0;
    int n;

    rect_fill_engine #(.H_RES(320), .V_RES(240)) dut (
        .CLOCK_50 (clk),
        .RESET    (RESET),
        .START    (START),
        .RECT_X0  (RECT_X0),
        .RECT_Y0  (RECT_Y0),
        .RECT_W   (RECT_W),
        .RECT_H   (RECT_H),
        .COLOR    (COLOR),
        .FLIP_REQ (FLIP_REQ),
        .VGA_VS   (VGA_VS),
        .WE       (WE),
        .PIXEL_X  (PIXEL_X),
        .PIXEL_Y  (PIXEL_Y),
        .PIXEL_DIN(PIXEL_DIN),
        .PAGE_SEL (PAGE_SEL),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (WE === 1'b1) wr_count++;
        if (DONE === 1'b1) done_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue START, then expect ew*eh raster writes starting at (x0,y0), then DONE.
    task automatic fill_check(input logic [8:0] x0, y0, w, h, input logic [7:0] c,
                              input int ew, input int eh);
        RECT_X0 = x0; RECT_Y0 = y0; RECT_W = w; RECT_H = h; COLOR = c;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("clip_we", WE, 1'b0);
        check("clip_busy", BUSY, 1'b1);
        tick();
        for (int r = 0; r < eh; r++) begin
            for (int col = 0; col < ew; col++) begin
                check("fill_we", WE, 1'b1);
                check("fill_x", PIXEL_X, 32'(x0) + 32'(col));
                check("fill_y", PIXEL_Y, 32'(y0) + 32'(r));
                check("fill_din", PIXEL_DIN, c);
                tick();
            end
        end
        check("fin_done", DONE, 1'b1);
        check("fin_we", WE, 1'b0);
        tick();
        check("done_pulse_end", DONE, 1'b0);
        check("idle_busy", BUSY, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_before, done_before;
        #1;
        tick();
        tick();
        check("rst_we", WE, 1'b0);
        check("rst_done", DONE, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_page", PAGE_SEL, 1'b0);
        check("rst_px", PIXEL_X, 9'd0);
        check("rst_py", PIXEL_Y, 9'd0);
        check("rst_din", PIXEL_DIN, 8'd0);
        RESET = 1'b0;
        tick();

        // 3x2 rectangle, no clipping
        wr_count = 0;
        fill_check(9'd10, 9'd20, 9'd3, 9'd2, 8'h5A, 3, 2);
        check("fill1_count", wr_count, 6);

        // clipped at the bottom-right corner
        wr_count = 0;
        fill_check(9'd318, 9'd238, 9'd5, 9'd5, 8'hC3, 2, 2);
        check("fill2_count", wr_count, 4);

        // empty rectangles
        wr_count = 0;
        fill_check(9'd50, 9'd50, 9'd0, 9'd4, 8'h11, 0, 0);
        fill_check(9'd320, 9'd10, 9'd5, 9'd5, 8'h22, 0, 0);
        check("empty_count", wr_count, 0);

        // 10x10 fill with a flip request and a vsync edge mid-fill
        wr_count = 0;
        done_before = done_count;
        RECT_X0 = 9'd0; RECT_Y0 = 9'd0; RECT_W = 9'd10; RECT_H = 9'd10; COLOR = 8'h77;
        START = 1'b1;
        tick();
        START = 1'b0;
        FLIP_REQ = 1'b1;
        tick();
        FLIP_REQ = 1'b0;
        VGA_VS = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("midfill_page", PAGE_SEL, 1'b0);
        check("midfill_busy", BUSY, 1'b1);
        FLIP_REQ = 1'b1;
        START = 1'b1;
        tick();
        FLIP_REQ = 1'b0;
        START = 1'b0;
        VGA_VS = 1'b1;
        n = 0;
        while (DONE !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check("flipfill_done_seen", DONE, 1'b1);
        check("flipfill_count", wr_count, 100);
        tick();
        check("pending_busy", BUSY, 1'b1);
        check("pending_page", PAGE_SEL, 1'b0);

        // START while a flip is pending must be ignored
        wr_before = wr_count;
        RECT_X0 = 9'd1; RECT_Y0 = 9'd1; RECT_W = 9'd2; RECT_H = 9'd2;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        check("pending_start_we", WE, 1'b0);
        check("pending_start_count", wr_count, wr_before);
        check("flipfill_done_count", done_count - done_before, 1);

        // next vsync edge in IDLE performs the flip
        VGA_VS = 1'b0;
        n = 0;
        while (PAGE_SEL !== 1'b1 && n < 6) begin
            tick();
            n++;
        end
        check("flip_page", PAGE_SEL, 1'b1);
        check("flip_latency", n, 3);
        check("flip_busy", BUSY, 1'b0);
        VGA_VS = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("flip_page_hold", PAGE_SEL, 1'b1);

        // reset after the 3rd write of a 4x4 fill
        wr_count = 0;
        done_before = done_count;
        RECT_X0 = 9'd5; RECT_Y0 = 9'd5; RECT_W = 9'd4; RECT_H = 9'd4; COLOR = 8'h99;
        START = 1'b1;
        tick();
        START = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_we", WE, 1'b1);
        check("pre_rst_x", PIXEL_X, 9'd7);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("abort_we", WE, 1'b0);
        check("abort_done", DONE, 1'b0);
        check("abort_page", PAGE_SEL, 1'b0);
        check("abort_busy", BUSY, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("abort_count", wr_count, 3);
        check("abort_no_done", done_count - done_before, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
